// File: rtl/alu_opcodes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_opcodes_pkg
// Description : Shared ALU opcode encodings, M-extension funct3 codes and the
//               sequential ALU FSM state type.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_opcodes_pkg;

    // Base ALU codes carried in op[4:0] when op[5] = 0.
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_SLL  = 5'd2;
    localparam logic [4:0] ALU_SLTS = 5'd3;
    localparam logic [4:0] ALU_SLTU = 5'd4;
    localparam logic [4:0] ALU_XOR  = 5'd5;
    localparam logic [4:0] ALU_SRL  = 5'd6;
    localparam logic [4:0] ALU_SRA  = 5'd7;
    localparam logic [4:0] ALU_OR   = 5'd8;
    localparam logic [4:0] ALU_AND  = 5'd9;
    localparam logic [4:0] ALU_EQ   = 5'd10;
    localparam logic [4:0] ALU_NE   = 5'd11;
    localparam logic [4:0] ALU_LTS  = 5'd12;
    localparam logic [4:0] ALU_LTU  = 5'd13;
    localparam logic [4:0] ALU_GES  = 5'd14;
    localparam logic [4:0] ALU_GEU  = 5'd15;

    // RV32M funct3 codes carried in op[2:0] when op[5] = 1.
    localparam logic [2:0] MDU_MUL    = 3'd0;
    localparam logic [2:0] MDU_MULH   = 3'd1;
    localparam logic [2:0] MDU_MULHSU = 3'd2;
    localparam logic [2:0] MDU_MULHU  = 3'd3;
    localparam logic [2:0] MDU_DIV    = 3'd4;
    localparam logic [2:0] MDU_DIVU   = 3'd5;
    localparam logic [2:0] MDU_REM    = 3'd6;
    localparam logic [2:0] MDU_REMU   = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } alu_state_e;

endpackage
`default_nettype wire

// File: rtl/alu_seq_riscv_mdu_iter.sv
`default_nettype none
// ============================================================================
// Module      : mdu_iter
// Description : Iterative multiply/divide unit. Radix-2 shift-add multiply and
//               restoring divide on operand magnitudes, one step per cycle for
//               XLEN cycles, sign fix-up applied to the final step's values.
// Revision    : 1.0 - initial release
// ============================================================================
module mdu_iter
    import alu_opcodes_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN);

    logic            busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [2:0]      op_q, op_d;
    logic            flip_res_q, flip_res_d;  // negate product / quotient
    logic            flip_rem_q, flip_rem_d;  // negate remainder
    logic [XLEN-1:0] acc_q, acc_d;            // product high half / remainder
    logic [XLEN-1:0] lo_q, lo_d;              // multiplier+product low / quotient
    logic [XLEN-1:0] opd_q, opd_d;            // multiplicand / divisor magnitude

    logic            sgn_a, sgn_b;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_sh;
    logic            div_ge;
    logic [XLEN-1:0] div_diff;
    logic [XLEN-1:0] acc_n, lo_n;
    logic [CW-1:0]   cnt_inc;
    logic [2*XLEN-1:0] prod, prod_s;
    logic [XLEN-1:0] quo_s, rem_s;

    // Operand signedness per op and magnitude extraction at start.
    always_comb begin
        sgn_a = 1'b0;
        sgn_b = 1'b0;
        case (op_i)
            MDU_MULH, MDU_DIV, MDU_REM: begin
                sgn_a = a_i[XLEN-1];
                sgn_b = b_i[XLEN-1];
            end
            MDU_MULHSU: sgn_a = a_i[XLEN-1];
            MDU_MUL, MDU_MULHU, MDU_DIVU, MDU_REMU: begin
                sgn_a = 1'b0;
                sgn_b = 1'b0;
            end
            default: ;
        endcase
        a_mag = sgn_a ? (~a_i + 1'b1) : a_i;
        b_mag = sgn_b ? (~b_i + 1'b1) : b_i;
    end

    // One multiply or divide step computed from the current registers.
    always_comb begin
        mul_sum  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opd_q} : {(XLEN+1){1'b0}});
        rem_sh   = {acc_q, lo_q[XLEN-1]};
        div_ge   = (rem_sh >= {1'b0, opd_q});
        // When div_ge holds the true difference is below 2^XLEN, so modular
        // XLEN-bit subtraction is exact.
        div_diff = rem_sh[XLEN-1:0] - opd_q;
        if (op_q[2]) begin
            acc_n = div_ge ? div_diff : rem_sh[XLEN-1:0];
            lo_n  = {lo_q[XLEN-2:0], div_ge};
        end else begin
            acc_n = mul_sum[XLEN:1];
            lo_n  = {mul_sum[0], lo_q[XLEN-1:1]};
        end
        cnt_inc = cnt_q + 1'b1;
    end

    // Next-state: load on start, otherwise step while busy until XLEN steps.
    always_comb begin
        busy_d     = busy_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        flip_res_d = flip_res_q;
        flip_rem_d = flip_rem_q;
        acc_d      = acc_q;
        lo_d       = lo_q;
        opd_d      = opd_q;
        if (start_i) begin
            busy_d     = 1'b1;
            cnt_d      = '0;
            op_d       = op_i;
            flip_res_d = sgn_a ^ sgn_b;
            flip_rem_d = sgn_a;
            acc_d      = '0;
            lo_d       = a_mag;
            opd_d      = b_mag;
        end else if (busy_q) begin
            cnt_d = cnt_inc;
            acc_d = acc_n;
            lo_d  = lo_n;
            if (cnt_inc == CNT_LAST) begin
                busy_d = 1'b0;
            end
        end
    end

    // Final result from the last step's values with sign fix-up.
    always_comb begin
        prod   = {acc_n, lo_n};
        prod_s = flip_res_q ? (~prod + 1'b1) : prod;
        quo_s  = flip_res_q ? (~lo_n + 1'b1) : lo_n;
        rem_s  = flip_rem_q ? (~acc_n + 1'b1) : acc_n;
        if (op_q[2]) begin
            result_o = op_q[1] ? rem_s : quo_s;
        end else begin
            result_o = (op_q[1:0] == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
        end
        done_o = busy_q && (cnt_inc == CNT_LAST);
    end

    // Iteration state registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            op_q       <= '0;
            flip_res_q <= 1'b0;
            flip_rem_q <= 1'b0;
            acc_q      <= '0;
            lo_q       <= '0;
            opd_q      <= '0;
        end else begin
            busy_q     <= busy_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            flip_res_q <= flip_res_d;
            flip_rem_q <= flip_rem_d;
            acc_q      <= acc_d;
            lo_q       <= lo_d;
            opd_q      <= opd_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_seq_riscv.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_riscv
// Description : Sequential RISC-V ALU with valid/ready handshakes. Base ops
//               and M-op corner cases answer in one cycle; regular multiply
//               and divide run XLEN cycles in mdu_iter.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_riscv
    import alu_opcodes_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit EN_MDU = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [5:0]      op_i,
    output logic            resp_valid_o,
    input  logic            resp_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            flag_o
);

    localparam int SHW = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    alu_state_e      state_q, state_d;
    logic [XLEN-1:0] result_q, result_d;
    logic            flag_q, flag_d;

    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] base_res;
    logic            base_flag;
    logic            is_m, b_zero, div_ovf;
    logic [XLEN-1:0] fast_res;
    logic            mdu_start, mdu_done;
    logic [XLEN-1:0] mdu_result;

    // Combinational base ALU and branch-compare flag.
    always_comb begin
        shamt     = b_i[SHW-1:0];
        base_res  = '0;
        base_flag = 1'b0;
        case (op_i[4:0])
            ALU_ADD:  base_res = a_i + b_i;
            ALU_SUB:  base_res = a_i - b_i;
            ALU_SLL:  base_res = a_i << shamt;
            ALU_SLTS: base_res = {{(XLEN-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
            ALU_SLTU: base_res = {{(XLEN-1){1'b0}}, (a_i < b_i)};
            ALU_XOR:  base_res = a_i ^ b_i;
            ALU_SRL:  base_res = a_i >> shamt;
            ALU_SRA:  base_res = $unsigned($signed(a_i) >>> shamt);
            ALU_OR:   base_res = a_i | b_i;
            ALU_AND:  base_res = a_i & b_i;
            ALU_EQ:   base_flag = (a_i == b_i);
            ALU_NE:   base_flag = (a_i != b_i);
            ALU_LTS:  base_flag = ($signed(a_i) < $signed(b_i));
            ALU_LTU:  base_flag = (a_i < b_i);
            ALU_GES:  base_flag = ($signed(a_i) >= $signed(b_i));
            ALU_GEU:  base_flag = (a_i >= b_i);
            default:  ;
        endcase
    end

    // Divide corner cases that bypass the iterative unit.
    always_comb begin
        is_m     = op_i[5];
        b_zero   = (b_i == '0);
        div_ovf  = ((op_i[2:0] == MDU_DIV) || (op_i[2:0] == MDU_REM)) &&
                   (a_i == MOST_NEG) && (b_i == '1);
        fast_res = '0;
        if (b_zero) begin
            fast_res = op_i[1] ? a_i : '1;          // REM/REMU : DIV/DIVU
        end else if (div_ovf) begin
            fast_res = (op_i[2:0] == MDU_DIV) ? a_i : '0;
        end
    end

    // FSM next-state and registered response capture.
    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        flag_d    = flag_q;
        mdu_start = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid_i) begin
                    if (!is_m || !EN_MDU) begin
                        result_d = is_m ? '0 : base_res;
                        flag_d   = is_m ? 1'b0 : base_flag;
                        state_d  = ST_DONE;
                    end else if (op_i[2] && (b_zero || div_ovf)) begin
                        result_d = fast_res;
                        flag_d   = 1'b0;
                        state_d  = ST_DONE;
                    end else begin
                        mdu_start = 1'b1;
                        state_d   = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (mdu_done) begin
                    result_d = mdu_result;
                    flag_d   = 1'b0;
                    state_d  = ST_DONE;
                end
            end
            ST_DONE: begin
                if (resp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and response registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= ST_IDLE;
            result_q <= '0;
            flag_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flag_q   <= flag_d;
        end
    end

    generate
        if (EN_MDU) begin : g_mdu
            mdu_iter #(
                .XLEN (XLEN)
            ) u_mdu_iter (
                .clk_i    (clk_i),
                .rst_i    (rst_i),
                .start_i  (mdu_start),
                .op_i     (op_i[2:0]),
                .a_i      (a_i),
                .b_i      (b_i),
                .done_o   (mdu_done),
                .result_o (mdu_result)
            );
        end else begin : g_no_mdu
            assign mdu_done   = 1'b0;
            assign mdu_result = '0;
        end
    endgenerate

    assign req_ready_o  = (state_q == ST_IDLE);
    assign resp_valid_o = (state_q == ST_DONE);
    assign result_o     = result_q;
    assign flag_o       = flag_q;

endmodule
`default_nettype wire
